// File: rtl/conv_pkg.sv
// Shared helpers for the convolution pipeline: expected window count per row
// and an elaboration-time parameter legality check.
package conv_pkg;

  function automatic int win_per_row(input int cols, input int mac_nb, input int stride);
    return ((cols - mac_nb) / stride) + 1;
  endfunction

endpackage

`define CONV_CHECK_PARAMS(COLS, MAC, STR) \
  if (((STR) < 1) || (conv_pkg::win_per_row((COLS), (MAC), (((STR) < 1) ? 1 : (STR))) < 1)) begin : g_param_error \
    $error("conv parameters illegal: IMG_COLS must be >= MAC_NB and STRIDE >= 1"); \
  end

// File: rtl/image_window.sv
// Turns a raster pixel stream into MAC_NB-wide horizontal windows with a
// configurable stride; windows never straddle a row boundary.
module image_window
  import conv_pkg::*;
#(
  parameter int MAC_NB      = 3,
  parameter int IMAGE_WIDTH = 16,
  parameter int IMG_COLS    = 32,
  parameter int STRIDE      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IMAGE_WIDTH-1:0]        pixel,
  input  logic                          pixel_valid,
  output logic [IMAGE_WIDTH*MAC_NB-1:0] image,
  output logic                          image_valid,
  output logic                          row_last
);

  `CONV_CHECK_PARAMS(IMG_COLS, MAC_NB, STRIDE)

  localparam int WIN_W  = IMAGE_WIDTH * MAC_NB;
  localparam int HIST_W = IMAGE_WIDTH * (MAC_NB - 1);
  localparam int COL_W  = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
  localparam int PH_W   = $clog2(STRIDE) + 1;

  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(MAC_NB - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_COLS - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(STRIDE - 1);

  // History holds the MAC_NB-1 most recent pixels; the incoming pixel completes the window.
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [WIN_W-1:0]  image_q, image_d;
  logic              image_valid_q, image_valid_d;
  logic              row_last_q, row_last_d;

  logic [WIN_W-1:0]  window;
  logic [PH_W-1:0]   phase_cur;
  logic              col_last;
  logic              emit;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    window        = {pixel, hist_q};
    col_last      = (col_q == COL_LAST);
    phase_cur     = (col_q == COL_FIRST) ? '0 : phase_q;
    emit          = pixel_valid && (col_q >= COL_FIRST) && (phase_cur == '0);

    hist_d        = hist_q;
    col_d         = col_q;
    phase_d       = phase_q;
    image_d       = image_q;
    image_valid_d = emit;
    row_last_d    = pixel_valid && col_last;

    if (pixel_valid) begin
      hist_d  = window[WIN_W-1:IMAGE_WIDTH];
      col_d   = col_last ? '0 : col_q + COL_W'(1);
      phase_d = (phase_cur == PH_LAST) ? '0 : phase_cur + PH_W'(1);
    end
    if (emit) begin
      image_d = window;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the pixel history is reset too, so a reset mid-row leaves no stale data behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q        <= '0;
      col_q         <= '0;
      phase_q       <= '0;
      image_q       <= '0;
      image_valid_q <= 1'b0;
      row_last_q    <= 1'b0;
    end else begin
      hist_q        <= hist_d;
      col_q         <= col_d;
      phase_q       <= phase_d;
      image_q       <= image_d;
      image_valid_q <= image_valid_d;
      row_last_q    <= row_last_d;
    end
  end

  assign image       = image_q;
  assign image_valid = image_valid_q;
  assign row_last    = row_last_q;

endmodule

// File: tb/tb_image_window.sv
// Directed bench for image_window: two instances (IMG_COLS=8, STRIDE 1 and 2)
// share the stimulus; each scenario task checks the instance it targets.
module tb_image_window;
  import conv_pkg::*;

  localparam int W    = 16;
  localparam int MACN = 3;
  localparam int COLS = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [W-1:0]         pixel = '0;
  logic                 pixel_valid = 1'b0;

  logic [W*MACN-1:0]    img1, img2, obs_img;
  logic                 v1, v2, obs_v;
  logic                 rl1, rl2, obs_rl;
  logic                 sel_s2 = 1'b0;

  int total = 0;
  int bad   = 0;
  int slice_q[$];

  image_window #(.MAC_NB(MACN), .IMAGE_WIDTH(W), .IMG_COLS(COLS), .STRIDE(1)) u_s1 (
    .clk(clk), .rst(rst), .pixel(pixel), .pixel_valid(pixel_valid),
    .image(img1), .image_valid(v1), .row_last(rl1));

  image_window #(.MAC_NB(MACN), .IMAGE_WIDTH(W), .IMG_COLS(COLS), .STRIDE(2)) u_s2 (
    .clk(clk), .rst(rst), .pixel(pixel), .pixel_valid(pixel_valid),
    .image(img2), .image_valid(v2), .row_last(rl2));

  assign obs_img = sel_s2 ? img2 : img1;
  assign obs_v   = sel_s2 ? v2   : v1;
  assign obs_rl  = sel_s2 ? rl2  : rl1;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slice model with weights 2,2,2: sum of weighted signed lanes.
  function automatic int slice_dot(input logic [W*MACN-1:0] win);
    int acc = 0;
    for (int k = 0; k < MACN; k++) acc += 2 * int'($signed(win[k*W +: W]));
    return acc;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    pixel_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Feeds one 8-pixel row starting at value 'first' (column 0 at the first pixel),
  // with 'gap' idle cycles after every pixel, checking outputs each cycle.
  task automatic run_row(input bit use_s2, input int first, input int gap,
                         input string tag, output int nwin);
    int               stride;
    bit               exp_emit;
    logic [W*MACN-1:0] exp_img;
    stride = use_s2 ? 2 : 1;
    sel_s2 = use_s2;
    nwin   = 0;
    for (int c = 0; c < COLS; c++) begin
      pixel       = W'(first + c);
      pixel_valid = 1'b1;
      @(negedge clk);
      pixel_valid = 1'b0;
      exp_emit = (c >= MACN - 1) && (((c - (MACN - 1)) % stride) == 0);
      exp_img  = {W'(first + c), W'(first + c - 1), W'(first + c - 2)};
      total++;
      if (obs_v !== exp_emit) begin
        bad++;
        $display("FAIL %s valid col=%0d: got %b want %b", tag, c, obs_v, exp_emit);
      end
      total++;
      if (obs_rl !== (c == COLS - 1)) begin
        bad++;
        $display("FAIL %s row_last col=%0d: got %b want %b", tag, c, obs_rl, (c == COLS - 1));
      end
      if (exp_emit) begin
        nwin++;
        total++;
        if (obs_img !== exp_img) begin
          bad++;
          $display("FAIL %s image col=%0d: got %h want %h", tag, c, obs_img, exp_img);
        end
      end
      if (obs_v === 1'b1) slice_q.push_back(slice_dot(obs_img));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        total++;
        if (obs_v !== 1'b0 || obs_rl !== 1'b0) begin
          bad++;
          $display("FAIL %s gap pulse col=%0d: got v=%b rl=%b want 0 0", tag, c, obs_v, obs_rl);
        end
        if (exp_emit) begin
          total++;
          if (obs_img !== exp_img) begin
            bad++;
            $display("FAIL %s gap hold col=%0d: got %h want %h", tag, c, obs_img, exp_img);
          end
        end
      end
    end
  endtask

  task automatic check_count(input string tag, input int got, input int stride);
    total++;
    if (got !== win_per_row(COLS, MACN, stride)) begin
      bad++;
      $display("FAIL %s window count: got %0d want %0d", tag, got, win_per_row(COLS, MACN, stride));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    total++;
    if (img1 !== '0 || v1 !== 1'b0 || rl1 !== 1'b0 || img2 !== '0 || v2 !== 1'b0 || rl2 !== 1'b0) begin
      bad++;
      $display("FAIL reset outputs: got img1=%h v1=%b rl1=%b img2=%h v2=%b rl2=%b want all 0",
               img1, v1, rl1, img2, v2, rl2);
    end
    do_reset();
  endtask

  task automatic test_stride1_rows();
    int n;
    do_reset();
    run_row(1'b0, 1, 0, "row1", n);
    check_count("row1", n, 1);
    run_row(1'b0, 9, 0, "row2", n);
    check_count("row2", n, 1);
  endtask

  task automatic test_stride2();
    int n;
    do_reset();
    run_row(1'b1, 1, 0, "stride2", n);
    check_count("stride2", n, 2);
  endtask

  task automatic test_gaps();
    int n;
    do_reset();
    run_row(1'b0, 1, 20, "gaps", n);
    check_count("gaps", n, 1);
  endtask

  task automatic test_async_reset();
    logic [W*MACN-1:0] exp_img;
    do_reset();
    sel_s2 = 1'b0;
    for (int p = 1; p <= 4; p++) begin
      pixel = W'(p);
      pixel_valid = 1'b1;
      @(negedge clk);
      pixel_valid = 1'b0;
    end
    total++;
    if (v1 !== 1'b1) begin
      bad++;
      $display("FAIL midrst pre valid: got %b want 1", v1);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (img1 !== '0 || v1 !== 1'b0) begin
      bad++;
      $display("FAIL midrst async clear: got img=%h v=%b want 0 0", img1, v1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_img = {16'd12, 16'd11, 16'd10};
    for (int i = 0; i < 3; i++) begin
      pixel = W'(10 + i);
      pixel_valid = 1'b1;
      @(negedge clk);
      pixel_valid = 1'b0;
      total++;
      if (v1 !== (i == 2)) begin
        bad++;
        $display("FAIL midrst post valid idx=%0d: got %b want %b", i, v1, (i == 2));
      end
    end
    total++;
    if (img1 !== exp_img) begin
      bad++;
      $display("FAIL midrst post image: got %h want %h", img1, exp_img);
    end
  endtask

  task automatic test_slice_chain();
    int n;
    int exp_res[6] = '{12, 18, 24, 30, 36, 42};
    do_reset();
    slice_q.delete();
    run_row(1'b0, 1, 0, "slice", n);
    total++;
    if (slice_q.size() !== 6) begin
      bad++;
      $display("FAIL slice count: got %0d want 6", slice_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (slice_q[i] !== exp_res[i]) begin
          bad++;
          $display("FAIL slice result %0d: got %0d want %0d", i, slice_q[i], exp_res[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stride1_rows();
    test_stride2();
    test_gaps();
    test_async_reset();
    test_slice_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
